commit_trace_buffer: RTL and testbench

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

---
 rtl/trace_pkg.sv | 22 ++
 rtl/trace_fifo.sv | 40 ++++
 rtl/commit_trace_buffer.sv | 80 ++++++++
 tb/tb_commit_trace_buffer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// trace_pkg: shared trace record type, store-size encoding and default buffer depth
package trace_pkg;
  localparam int DEPTH_DEFAULT = 8;
  typedef enum logic [1:0] {
    WOP_NONE = 2'd0,
    WOP_BYTE = 2'd1,
    WOP_HALF = 2'd2,
    WOP_WORD = 2'd3
  } wop_e;
  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] rd_data;
    logic [1:0]  wop;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } trace_rec_t;
  localparam int REC_W = $bits(trace_rec_t);
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO (push/din in; pop in; dout/full/empty/level out), pop frees room for a same-cycle push
module trace_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] level_q, level_d;
  logic push_ok, pop_ok;
  assign empty = level_q == '0;
  assign full = level_q == (AW+1)'(DEPTH);
  assign pop_ok = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout = empty ? '0 : mem_q[rd_q];
  assign level = level_q;
  always_comb level_d = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(push_ok);
      rd_q <= rd_q + AW'(pop_ok);
      level_q <= level_d;
    end
  end
  always_ff @(posedge clk) if (push_ok) mem_q[wr_q] <= din;
endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: normalises retirements (retire_* in) into seq-numbered records on out_valid/out_ready/out_rec, with level/overflow/drop_count status
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trace_en,
  input  logic                   retire_valid,
  input  logic [31:0]            retire_pc,
  input  logic [31:0]            retire_instr,
  input  logic [4:0]             retire_rd,
  input  logic                   retire_rd_we,
  input  logic [31:0]            retire_rd_data,
  input  logic [1:0]             retire_wop,
  input  logic [31:0]            retire_waddr,
  input  logic [31:0]            retire_wdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output trace_rec_t             out_rec,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_count
);
  trace_rec_t rec_d;
  logic [REC_W-1:0] fifo_dout;
  logic [31:0] seq_q;
  logic [CNT_W-1:0] drop_q;
  logic overflow_q, cap, full, empty, stored, dropped;
  wop_e wop;
  assign wop = wop_e'(retire_wop);
  assign cap = retire_valid & trace_en;
  // A pop in the same cycle frees a slot, so only a full buffer with no pop drops
  assign stored = cap & (~full | (out_valid & out_ready));
  assign dropped = cap & ~stored;
  assign out_valid = ~empty;
  assign out_rec = trace_rec_t'(fifo_dout);
  assign overflow = overflow_q;
  assign drop_count = drop_q;
  always_comb begin
    rec_d = '0;
    rec_d.seq = seq_q;
    rec_d.pc = retire_pc;
    rec_d.instr = retire_instr;
    rec_d.rd = retire_rd;
    rec_d.rd_we = retire_rd_we & (|retire_rd);
    rec_d.rd_data = (|retire_rd) ? retire_rd_data : '0;
    rec_d.wop = retire_wop;
    rec_d.waddr = wop == WOP_NONE ? '0 : retire_waddr;
    rec_d.wdata = wop == WOP_BYTE ? {24'b0, retire_wdata[7:0]} :
                  wop == WOP_HALF ? {16'b0, retire_wdata[15:0]} :
                  wop == WOP_WORD ? retire_wdata : '0;
  end
  trace_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(cap),
    .din(rec_d),
    .pop(out_ready),
    .dout(fifo_dout),
    .full(full),
    .empty(empty),
    .level(level)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q <= '0;
      drop_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      seq_q <= seq_q + 32'(stored);
      if (dropped) begin
        overflow_q <= 1'b1;
        drop_q <= (&drop_q) ? drop_q : drop_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: random and directed stimulus checked against a queue-based trace model
module tb_commit_trace_buffer;
  import trace_pkg::*;
  localparam int D = 8;
  localparam int CW = 4;
  localparam int DROP_MAX = (1 << CW) - 1;
  logic clk = 0, reset = 1, trace_en = 1, retire_valid = 0, retire_rd_we = 0, out_ready = 0;
  logic [31:0] retire_pc = 0, retire_instr = 0, retire_rd_data = 0, retire_waddr = 0, retire_wdata = 0;
  logic [4:0] retire_rd = 0;
  logic [1:0] retire_wop = 0;
  logic out_valid, overflow;
  trace_rec_t out_rec;
  logic [$clog2(D):0] level;
  logic [CW-1:0] drop_count;
  int checks = 0, errors = 0;
  trace_rec_t mq[$];
  int unsigned m_seq = 0;
  int m_drop = 0;
  bit m_ovf = 0;
  int unsigned s;
  commit_trace_buffer #(.DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .trace_en(trace_en), .retire_valid(retire_valid),
    .retire_pc(retire_pc), .retire_instr(retire_instr), .retire_rd(retire_rd),
    .retire_rd_we(retire_rd_we), .retire_rd_data(retire_rd_data), .retire_wop(retire_wop),
    .retire_waddr(retire_waddr), .retire_wdata(retire_wdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_rec(out_rec), .level(level), .overflow(overflow),
    .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic trace_rec_t model_rec();
    trace_rec_t r;
    int bytes;
    bytes = retire_wop == 3 ? 4 : int'(retire_wop);
    r = '0;
    r.seq = m_seq;
    r.pc = retire_pc;
    r.instr = retire_instr;
    r.rd = retire_rd;
    r.rd_we = retire_rd_we && retire_rd != 0;
    r.rd_data = retire_rd != 0 ? retire_rd_data : 32'd0;
    r.wop = retire_wop;
    r.waddr = bytes == 0 ? 32'd0 : retire_waddr;
    r.wdata = 32'(64'(retire_wdata) % (64'd1 << (8 * bytes)));
    if (bytes == 0) r.wdata = 0;
    return r;
  endfunction
  task automatic model_edge();
    bit pop, room;
    if (reset) begin
      mq.delete();
      m_seq = 0;
      m_drop = 0;
      m_ovf = 0;
    end else begin
      pop = mq.size() > 0 && out_ready;
      room = mq.size() < D || pop;
      if (retire_valid && trace_en) begin
        if (room) begin
          mq.push_back(model_rec());
          m_seq++;
        end else begin
          m_ovf = 1;
          if (m_drop < DROP_MAX) m_drop++;
        end
      end
      if (pop) void'(mq.pop_front());
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("level", 256'(level), 256'(mq.size()));
    chk("out_valid", 256'(out_valid), 256'(mq.size() > 0));
    chk("overflow", 256'(overflow), 256'(m_ovf));
    chk("drop_count", 256'(drop_count), 256'(m_drop));
    if (mq.size() > 0) chk("out_rec", 256'(out_rec), 256'(mq[0]));
  endtask
  task automatic rnd_retire();
    retire_valid = 1;
    retire_pc = $urandom;
    retire_instr = $urandom;
    retire_rd = 5'($urandom_range(0, 31));
    retire_rd_we = 1'($urandom);
    retire_rd_data = $urandom;
    retire_wop = 2'($urandom_range(0, 3));
    retire_waddr = $urandom;
    retire_wdata = $urandom;
  endtask
  initial begin
    cyc();
    cyc();
    chk("rst_rec", 256'(out_rec), 256'(0));
    chk("rst_level", 256'(level), 256'(0));
    reset = 0;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      rnd_retire();
      retire_pc = 32'(i * 4);
      cyc();
      chk("r39_valid", 256'(out_valid), 256'(1));
      chk("r39_seq", 256'(out_rec.seq), 256'(i));
      chk("r39_pc", 256'(out_rec.pc), 256'(i * 4));
    end
    retire_valid = 0;
    cyc();
    cyc();
    reset = 1;
    cyc();
    reset = 0;
    out_ready = 0;
    for (int i = 0; i < 10; i++) begin
      rnd_retire();
      cyc();
    end
    chk("r40_level", 256'(level), 256'(8));
    chk("r40_ovf", 256'(overflow), 256'(1));
    chk("r40_drop", 256'(drop_count), 256'(2));
    chk("r40_head", 256'(out_rec.seq), 256'(0));
    out_ready = 1;
    rnd_retire();
    cyc();
    chk("r41_level", 256'(level), 256'(8));
    chk("r41_drop", 256'(drop_count), 256'(2));
    retire_valid = 0;
    for (int k = 1; k <= 8; k++) begin
      chk("r40_drain", 256'(out_rec.seq), 256'(k));
      cyc();
    end
    chk("r40_empty", 256'(out_valid), 256'(0));
    out_ready = 0;
    rnd_retire();
    retire_rd = 0;
    retire_rd_we = 1;
    retire_rd_data = 32'hDEADBEEF;
    retire_wop = 1;
    retire_wdata = 32'h12345678;
    cyc();
    chk("r42_rd_we", 256'(out_rec.rd_we), 256'(0));
    chk("r42_rd_data", 256'(out_rec.rd_data), 256'(0));
    chk("r42_wdata", 256'(out_rec.wdata), 256'(32'h78));
    out_ready = 1;
    rnd_retire();
    retire_wop = 0;
    cyc();
    chk("wop0_waddr", 256'(out_rec.waddr), 256'(0));
    chk("wop0_wdata", 256'(out_rec.wdata), 256'(0));
    rnd_retire();
    retire_wop = 2;
    retire_wdata = 32'hCAFEF00D;
    cyc();
    chk("wop2_wdata", 256'(out_rec.wdata), 256'(32'hF00D));
    retire_valid = 0;
    cyc();
    s = m_seq;
    trace_en = 0;
    for (int i = 0; i < 5; i++) begin
      rnd_retire();
      cyc();
    end
    chk("r43_level", 256'(level), 256'(0));
    chk("r43_drop", 256'(drop_count), 256'(2));
    trace_en = 1;
    out_ready = 0;
    rnd_retire();
    cyc();
    chk("r43_seq", 256'(out_rec.seq), 256'(s));
    for (int i = 0; i < 30; i++) begin
      rnd_retire();
      cyc();
    end
    chk("drop_sat", 256'(drop_count), 256'(DROP_MAX));
    for (int i = 0; i < 400; i++) begin
      rnd_retire();
      retire_valid = ($urandom % 4) != 0;
      trace_en = ($urandom % 8) != 0;
      out_ready = 1'($urandom);
      cyc();
    end
    trace_en = 1;
    reset = 1;
    cyc();
    reset = 0;
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      rnd_retire();
      cyc();
    end
    chk("r44_pre", 256'(level), 256'(5));
    reset = 1;
    out_ready = 1;
    rnd_retire();
    cyc();
    chk("r44_level", 256'(level), 256'(0));
    chk("r44_valid", 256'(out_valid), 256'(0));
    chk("r44_ovf", 256'(overflow), 256'(0));
    reset = 0;
    out_ready = 0;
    rnd_retire();
    cyc();
    chk("r44_seq", 256'(out_rec.seq), 256'(0));
    chk("r44_lvl1", 256'(level), 256'(1));
    retire_valid = 0;
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
